// File: rtl/pipelined_floating_point_adder.sv
// Three-stage pipelined floating-point adder/subtractor with valid/ready flow control.
// Stages: unpack/align, significand add, normalize/round with registered result and flags.
module pipelined_floating_point_adder #(
    parameter int ExponentWidth = 8,
    parameter int MantissaWidth = 23,
    localparam int FloatBitWidth = ExponentWidth + MantissaWidth + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [FloatBitWidth-1:0] a,
    input  logic [FloatBitWidth-1:0] b,
    input  logic                     subtract,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [FloatBitWidth-1:0] out,
    output logic                     underflow_flag,
    output logic                     overflow_flag,
    output logic                     invalid_operation_flag,
    output logic                     inexact_flag
);
    localparam int EW  = ExponentWidth;
    localparam int MW  = MantissaWidth;
    localparam int FW  = FloatBitWidth;
    localparam int SW  = MW + 4;           // hidden bit, fraction, guard, round, sticky
    localparam int SEW = EW + 2;
    localparam int LZW = $clog2(SW);
    localparam logic [EW-1:0] EXP_ONES = '1;
    localparam logic [FW-1:0] CANON_NAN = {1'b1, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
    localparam logic signed [SEW-1:0] EXP_MAX  = SEW'((1 << EW) - 1);
    localparam logic signed [SEW-1:0] EXP_ZERO = '0;

    // Handshake: a beat moves between two places exactly when the source holds valid
    // data and the destination is empty or is itself moving on this edge.
    logic s1_valid, s2_valid;
    logic en1, en2, en3;
    assign en3      = !out_valid || out_ready;
    assign en2      = !s2_valid || en3;
    assign en1      = !s1_valid || en2;
    assign in_ready = en1;

    logic          sign_a, sign_b, zero_a, zero_b, inf_a, inf_b;
    logic          qnan_a, qnan_b, snan_a, snan_b;
    logic [EW-1:0] exp_a, exp_b;
    logic [MW-1:0] frac_a, frac_b, frac_a_f, frac_b_f;

    always_comb begin
        sign_a   = a[FW-1];
        sign_b   = b[FW-1] ^ subtract;
        exp_a    = a[FW-2:MW];
        exp_b    = b[FW-2:MW];
        frac_a   = a[MW-1:0];
        frac_b   = b[MW-1:0];
        zero_a   = (exp_a == '0);
        zero_b   = (exp_b == '0);
        inf_a    = (exp_a == EXP_ONES) && (frac_a == '0);
        inf_b    = (exp_b == EXP_ONES) && (frac_b == '0);
        qnan_a   = (exp_a == EXP_ONES) && frac_a[MW-1];
        qnan_b   = (exp_b == EXP_ONES) && frac_b[MW-1];
        snan_a   = (exp_a == EXP_ONES) && !frac_a[MW-1] && (frac_a != '0);
        snan_b   = (exp_b == EXP_ONES) && !frac_b[MW-1] && (frac_b != '0);
        frac_a_f = zero_a ? '0 : frac_a;   // subnormals flush to signed zero
        frac_b_f = zero_b ? '0 : frac_b;
    end

    logic          a_big, sign_l;
    logic [EW-1:0] exp_l, exp_diff;
    logic [SW-1:0] sig_l, sig_s, sig_s_al, lost_mask;

    always_comb begin
        a_big = {exp_a, frac_a_f} >= {exp_b, frac_b_f};
        if (a_big) begin
            sign_l   = sign_a;
            exp_l    = exp_a;
            exp_diff = exp_a - exp_b;
            sig_l    = {!zero_a, frac_a_f, 3'b000};
            sig_s    = {!zero_b, frac_b_f, 3'b000};
        end else begin
            sign_l   = sign_b;
            exp_l    = exp_b;
            exp_diff = exp_b - exp_a;
            sig_l    = {!zero_b, frac_b_f, 3'b000};
            sig_s    = {!zero_a, frac_a_f, 3'b000};
        end
        lost_mask = ~({SW{1'b1}} << exp_diff);
        if (int'(exp_diff) >= SW)
            sig_s_al = {{(SW-1){1'b0}}, |sig_s};
        else
            sig_s_al = (sig_s >> exp_diff) | {{(SW-1){1'b0}}, |(sig_s & lost_mask)};
    end

    logic          spec_hit, spec_inv, spec_ovf;
    logic [FW-1:0] spec_val;

    always_comb begin
        spec_hit = 1'b1;
        spec_val = '0;
        spec_inv = 1'b0;
        spec_ovf = 1'b0;
        if (snan_a || snan_b) begin
            spec_val = CANON_NAN;
            spec_inv = 1'b1;
        end else if (qnan_a) begin
            spec_val = a;
            spec_inv = 1'b1;
        end else if (qnan_b) begin
            spec_val = {sign_b, b[FW-2:0]};
            spec_inv = 1'b1;
        end else if (inf_a && inf_b && (sign_a != sign_b)) begin
            spec_val = CANON_NAN;
            spec_inv = 1'b1;
        end else if (inf_a) begin
            spec_val = a;
            spec_ovf = 1'b1;
        end else if (inf_b) begin
            spec_val = {sign_b, b[FW-2:0]};
            spec_ovf = 1'b1;
        end else if (zero_a && zero_b) begin
            spec_val = {sign_a & sign_b, {(FW-1){1'b0}}};
        end else begin
            spec_hit = 1'b0;
        end
    end

    logic          s1_special, s1_inv, s1_ovf, s1_sign, s1_sub;
    logic [FW-1:0] s1_spec_val;
    logic [EW-1:0] s1_exp;
    logic [SW-1:0] s1_sig_l, s1_sig_s;

    logic          s2_special, s2_inv, s2_ovf, s2_sign;
    logic [FW-1:0] s2_spec_val;
    logic [EW-1:0] s2_exp;
    logic [SW:0]   s2_sum, sum;

    // Larger magnitude is always sig_l, so subtraction never goes negative.
    assign sum = s1_sub ? ({1'b0, s1_sig_l} - {1'b0, s1_sig_s})
                        : ({1'b0, s1_sig_l} + {1'b0, s1_sig_s});

    logic                  carry, g_bit, r_bit, st_bit, lsb_bit, rnd_up;
    logic [LZW-1:0]        lzc;
    logic [SW-1:0]         norm_sig;
    logic [MW+1:0]         mant_rnd;
    logic [MW-1:0]         frac_fin;
    logic signed [SEW-1:0] exp_base, exp_adj, exp_fin;
    logic [FW-1:0]         res_val;
    logic                  res_unf, res_ovf, res_inv, res_inx;

    always_comb begin
        carry = s2_sum[SW];
        lzc   = '0;
        for (int i = 0; i < SW; i++) begin
            if (s2_sum[i]) lzc = LZW'(SW - 1 - i);
        end
        if (carry) norm_sig = {s2_sum[SW:2], s2_sum[1] | s2_sum[0]};
        else       norm_sig = s2_sum[SW-1:0] << lzc;
        exp_base = {2'b00, s2_exp};
        exp_adj  = carry ? exp_base + SEW'(1) : exp_base - SEW'(lzc);
        lsb_bit  = norm_sig[3];
        g_bit    = norm_sig[2];
        r_bit    = norm_sig[1];
        st_bit   = norm_sig[0];
        rnd_up   = g_bit && (r_bit || st_bit || lsb_bit);
        mant_rnd = {1'b0, norm_sig[SW-1:3]} + {{(MW+1){1'b0}}, rnd_up};
        exp_fin  = exp_adj + {{(SEW-1){1'b0}}, mant_rnd[MW+1]};
        frac_fin = mant_rnd[MW+1] ? mant_rnd[MW:1] : mant_rnd[MW-1:0];

        res_val = '0;
        res_unf = 1'b0;
        res_ovf = 1'b0;
        res_inv = 1'b0;
        res_inx = 1'b0;
        if (s2_special) begin
            res_val = s2_spec_val;
            res_inv = s2_inv;
            res_ovf = s2_ovf;
        end else if (s2_sum == '0) begin
            res_val = '0;
        end else if (exp_fin >= EXP_MAX) begin
            res_val = {s2_sign, EXP_ONES, {MW{1'b0}}};
            res_ovf = 1'b1;
            res_inx = 1'b1;
        end else if (exp_fin <= EXP_ZERO) begin
            res_val = {s2_sign, {(FW-1){1'b0}}};
            res_unf = 1'b1;
            res_inx = 1'b1;
        end else begin
            res_val = {s2_sign, exp_fin[EW-1:0], frac_fin};
            res_inx = g_bit || r_bit || st_bit;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid               <= 1'b0;
            s1_special             <= 1'b0;
            s1_inv                 <= 1'b0;
            s1_ovf                 <= 1'b0;
            s1_sign                <= 1'b0;
            s1_sub                 <= 1'b0;
            s1_spec_val            <= '0;
            s1_exp                 <= '0;
            s1_sig_l               <= '0;
            s1_sig_s               <= '0;
            s2_valid               <= 1'b0;
            s2_special             <= 1'b0;
            s2_inv                 <= 1'b0;
            s2_ovf                 <= 1'b0;
            s2_sign                <= 1'b0;
            s2_spec_val            <= '0;
            s2_exp                 <= '0;
            s2_sum                 <= '0;
            out_valid              <= 1'b0;
            out                    <= '0;
            underflow_flag         <= 1'b0;
            overflow_flag          <= 1'b0;
            invalid_operation_flag <= 1'b0;
            inexact_flag           <= 1'b0;
        end else begin
            if (en3) begin
                out_valid <= s2_valid;
                if (s2_valid) begin
                    out                    <= res_val;
                    underflow_flag         <= res_unf;
                    overflow_flag          <= res_ovf;
                    invalid_operation_flag <= res_inv;
                    inexact_flag           <= res_inx;
                end
            end
            if (en2) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_special  <= s1_special;
                    s2_inv      <= s1_inv;
                    s2_ovf      <= s1_ovf;
                    s2_sign     <= s1_sign;
                    s2_spec_val <= s1_spec_val;
                    s2_exp      <= s1_exp;
                    s2_sum      <= sum;
                end
            end
            if (en1) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_special  <= spec_hit;
                    s1_inv      <= spec_inv;
                    s1_ovf      <= spec_ovf;
                    s1_sign     <= sign_l;
                    s1_sub      <= sign_a ^ sign_b;
                    s1_spec_val <= spec_val;
                    s1_exp      <= exp_l;
                    s1_sig_l    <= sig_l;
                    s1_sig_s    <= sig_s_al;
                end
            end
        end
    end
endmodule

// File: tb/tb_pipelined_floating_point_adder.sv
// Directed bench for the pipelined adder: single and half precision instances,
// scoreboard on the single-precision output stream, stall and reset scenarios.
module tb_pipelined_floating_point_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, subtract, out_valid, out_ready;
    logic [31:0] a, b, out;
    logic        underflow_flag, overflow_flag, invalid_operation_flag, inexact_flag;

    logic        h_in_valid, h_in_ready, h_subtract, h_out_valid, h_out_ready;
    logic [15:0] h_a, h_b, h_out;
    logic        h_unf, h_ovf, h_inv, h_inx;

    pipelined_floating_point_adder #(.ExponentWidth(8), .MantissaWidth(23)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .subtract(subtract), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .underflow_flag(underflow_flag), .overflow_flag(overflow_flag),
        .invalid_operation_flag(invalid_operation_flag), .inexact_flag(inexact_flag)
    );

    pipelined_floating_point_adder #(.ExponentWidth(5), .MantissaWidth(10)) dut_h (
        .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .a(h_a), .b(h_b), .subtract(h_subtract), .out_valid(h_out_valid), .out_ready(h_out_ready),
        .out(h_out), .underflow_flag(h_unf), .overflow_flag(h_ovf),
        .invalid_operation_flag(h_inv), .inexact_flag(h_inx)
    );

    int checks = 0;
    int failures = 0;
    logic [35:0] exp_q[$];

    // Expected words are {invalid, overflow, underflow, inexact, result}.
    localparam int NV = 16;
    localparam logic [31:0] VA [NV] = '{
        32'h40400000, 32'h410B3333, 32'h7F800000, 32'h00000000,
        32'h3F800000, 32'h3F800000, 32'h7F7FFFFF, 32'hFFA00000,
        32'hFFC00000, 32'h40800000, 32'h3F800000, 32'h00800001,
        32'h00000000, 32'hFF800000, 32'h80000000, 32'h40400000};
    localparam logic [31:0] VB [NV] = '{
        32'h40800000, 32'h3E99999A, 32'h7F800000, 32'h80000000,
        32'h33800000, 32'h33800001, 32'h7F7FFFFF, 32'h00000000,
        32'h00000000, 32'h40400000, 32'h40400000, 32'h00800000,
        32'h7FC00001, 32'h40A00000, 32'h80000000, 32'h40400000};
    localparam logic VS [NV] = '{
        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
        1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    localparam logic [35:0] VE [NV] = '{
        {4'b0000, 32'h40E00000}, {4'b0001, 32'h41100000},
        {4'b1000, 32'hFFC00000}, {4'b0000, 32'h00000000},
        {4'b0001, 32'h3F800000}, {4'b0001, 32'h3F800001},
        {4'b0101, 32'h7F800000}, {4'b1000, 32'hFFC00000},
        {4'b1000, 32'hFFC00000}, {4'b0000, 32'h3F800000},
        {4'b0000, 32'hC0000000}, {4'b0011, 32'h00000000},
        {4'b1000, 32'hFFC00001}, {4'b0100, 32'hFF800000},
        {4'b0000, 32'h80000000}, {4'b0000, 32'h00000000}};

    task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [35:0] obs();
        return {invalid_operation_flag, overflow_flag, underflow_flag, inexact_flag, out};
    endfunction

    // Called at posedge+1; returns at posedge+1 right after the transfer edge.
    task automatic drive_op(input logic [31:0] av, input logic [31:0] bv,
                            input logic sv, input logic [35:0] ev);
        bit done;
        done = 1'b0;
        a = av;
        b = bv;
        subtract = sv;
        in_valid = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(ev);
                done = 1'b1;
            end
        end
        if (!done) check("in_ready_timeout", {35'b0, in_ready}, 36'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) check("spurious", {35'b0, out_valid}, 36'd0);
                else check("stream", obs(), exp_q.pop_front());
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    int lat, hlat;
    logic [35:0] hres;

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; subtract = 1'b0; out_ready = 1'b1;
        h_in_valid = 1'b0; h_a = '0; h_b = '0; h_subtract = 1'b0; h_out_ready = 1'b1;
        @(negedge clk);
        check("rst_out", obs(), 36'd0);
        check("rst_valid", {35'b0, out_valid}, 36'd0);
        check("rst_in_ready", {35'b0, in_ready}, 36'd1);
        check("rst_h_valid", {35'b0, h_out_valid}, 36'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Single op latency: transfer edge counts as edge 1.
        a = 32'h40400000; b = 32'h40800000; subtract = 1'b0; in_valid = 1'b1;
        exp_q.push_back({4'b0000, 32'h40E00000});
        lat = 0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (out_valid && lat == 0) lat = n;
        end
        check("latency", 36'(lat), 36'd3);

        for (int i = 0; i < NV; i++) drive_op(VA[i], VB[i], VS[i], VE[i]);
        repeat (8) @(posedge clk);
        #1;

        // Backpressure: four ops against a stalled sink.
        out_ready = 1'b0;
        fork
            begin
                drive_op(32'h40400000, 32'h40800000, 1'b0, {4'b0000, 32'h40E00000});
                drive_op(32'h40800000, 32'h40400000, 1'b1, {4'b0000, 32'h3F800000});
                drive_op(32'h3F800000, 32'h40400000, 1'b1, {4'b0000, 32'hC0000000});
                drive_op(32'h80000000, 32'h80000000, 1'b0, {4'b0000, 32'h80000000});
            end
            begin
                repeat (4) @(negedge clk);
                for (int i = 0; i < 5; i++) begin
                    check("bp_in_ready", {35'b0, in_ready}, 36'd0);
                    check("bp_valid", {35'b0, out_valid}, 36'd1);
                    check("bp_hold", obs(), {4'b0000, 32'h40E00000});
                    @(negedge clk);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        repeat (10) @(posedge clk);
        #1;

        // Asynchronous reset with the pipeline full and an overflow result on the output.
        out_ready = 1'b0;
        drive_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, {4'b0101, 32'h7F800000});
        drive_op(32'h40400000, 32'h40800000, 1'b0, {4'b0000, 32'h40E00000});
        drive_op(32'h3F800000, 32'h33800001, 1'b0, {4'b0001, 32'h3F800001});
        check("pre_rst_out", obs(), {4'b0101, 32'h7F800000});
        h_a = 16'h4200; h_b = 16'h4400; h_in_valid = 1'b1;
        @(posedge clk); #1;
        h_in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", {35'b0, out_valid}, 36'd0);
        check("async_rst_out", obs(), 36'd0);
        check("async_rst_h_valid", {35'b0, h_out_valid}, 36'd0);
        exp_q.delete();
        @(posedge clk); #3;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_valid", {35'b0, out_valid}, 36'd0);
            check("post_rst_h_valid", {35'b0, h_out_valid}, 36'd0);
        end

        // Half precision: 3.0 + 4.0 = 7.0.
        @(posedge clk); #1;
        h_a = 16'h4200; h_b = 16'h4400; h_subtract = 1'b0; h_in_valid = 1'b1;
        hlat = 0;
        hres = '0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            h_in_valid = 1'b0;
            if (h_out_valid && hlat == 0) begin
                hlat = n;
                hres = {h_inv, h_ovf, h_unf, h_inx, 16'h0000, h_out};
            end
        end
        check("h_latency", 36'(hlat), 36'd3);
        check("h_sum", hres, {4'b0000, 16'h0000, 16'h4700});

        repeat (4) @(posedge clk);
        check("drain", 36'(exp_q.size()), 36'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipelined_floating_point_adder.md
Name: pipelined_floating_point_adder

Overview:
Three-stage pipelined IEEE-754-style adder/subtractor, parametrised in exponent and mantissa width. It is the clocked successor of the combinational floating_point_adder.
- Adds a valid/ready handshake with backpressure.
- Rounds to nearest, ties to even.
- Adds an inexact flag.
- Registers all exception flags alongside the result.

It sits in datapaths that need one result per cycle at high clock rates.

Parameters:
ExponentWidth, 8, exponent field width (>=3)
MantissaWidth, 23, stored fraction width (>=2); FloatBitWidth = ExponentWidth+MantissaWidth+1

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  a/b/subtract valid this cycle
in_ready  output  1  pipeline can accept an operand pair
a  input  FloatBitWidth  operand A
b  input  FloatBitWidth  operand B
subtract  input  1  1: compute a-b (invert sign of b)
out_valid  output  1  out and flags valid
out_ready  input  1  downstream accepts result
out  output  FloatBitWidth  result
underflow_flag  output  1  result flushed to zero from nonzero exact sum
overflow_flag  output  1  result is infinity
invalid_operation_flag  output  1  NaN operand or Inf-Inf
inexact_flag  output  1  rounded result differs from exact sum

Behaviour:
Reset:
- rst high immediately clears all stage valid bits, out_valid=0, out=0, all flags=0.
- Reset mid-operation discards in-flight data. No result emerges after reset deasserts.

Handshake:
- Input transfer occurs when in_valid&&in_ready. Output transfer occurs when out_valid&&out_ready.
- The pipeline advances when out_ready || !out_valid. Any stage may also fill if the stage ahead is empty (bubble collapse).
- in_ready = !s1_valid || stage 1 can advance. It is combinational from out_ready.
- While stalled, out and flags hold stable.
- Latency: exactly 3 cycles from input transfer to out_valid with no stall. Throughput: 1 per cycle.

Stage 1, unpack/align:
- Apply subtract to b sign.
- Classify each operand as zero, subnormal, normal, Inf, QNaN (fraction MSB=1) or SNaN.
- Subnormal inputs are flushed to signed zero.
- Swap so the larger magnitude is first.
- Right-shift the smaller significand by the exponent difference, keeping guard, round and sticky bits. A shift >= MantissaWidth+3 leaves sticky only.

Stage 2, add:
- Add or subtract significands in MantissaWidth+4 bits plus carry. Carry the special-case result forward unchanged.

Stage 3, normalize/round:
- Leading-zero count and left shift, or 1-bit right shift on carry.
- Round to nearest even using guard/round/sticky. Renormalize on rounding carry.
- Exponent arithmetic is done in ExponentWidth+2 signed bits.
  - Biased exponent >= all-ones gives signed Inf, overflow_flag=1, inexact_flag=1.
  - Biased exponent <= 0 gives signed zero, underflow_flag=1, inexact_flag=1.

Special cases, in priority order:
1. Either operand SNaN: out = canonical QNaN {1, all-ones exponent, 1, zeros}, e.g. 32'hFFC00000; invalid=1.
2. a QNaN: out=a; invalid=1. Else b QNaN: out=b, with the sign after subtract applied; invalid=1.
3. Inf + (-Inf) after subtract: canonical QNaN; invalid=1.
4. Any Inf operand: out = that Inf; overflow_flag=1.
5. Exact zero sum: +0, except (-0)+(-0) = -0. No flags.

Flags are per result; they are not sticky.

Test Plan:
- Latency and basic add: a=32'h40400000, b=32'h40800000, subtract=0, out_ready=1 -> out_valid on 3rd clock after transfer, out=32'h40E00000, all flags 0.
- Back-to-back stream: 4 consecutive cycles of (3.0+4.0), (8.7+0.3 = 32'h410B3333+32'h3E99999A), (32'h7F800000-32'h7F800000), (32'h00000000+32'h80000000) -> out in order, one per cycle: 32'h40E00000, 32'h41100000, 32'hFFC00000 with invalid=1, 32'h00000000.
- Backpressure: hold out_ready=0 for 5 cycles with 4 ops in flight -> in_ready=0 once 3 stages plus output are full. out and flags stay constant. No loss or duplication after out_ready=1.
- Rounding ties: 32'h3F800000+32'h33800000 -> 32'h3F800000, inexact=1. 32'h3F800000+32'h33800001 -> 32'h3F800001, inexact=1.
- Overflow and NaN: 32'h7F7FFFFF+32'h7F7FFFFF -> 32'h7F800000, overflow=1. 32'hFFA00000+0 -> 32'hFFC00000, invalid=1. 32'hFFC00000+0 -> 32'hFFC00000, invalid=1.
- Reset mid-operation: assert rst asynchronously with 2 ops in flight -> out_valid=0 and flags 0 immediately. No stale result appears after release. Repeat with ExponentWidth=5, MantissaWidth=10: 16'h4200+16'h4400 -> 16'h4700.
